cpu_seq_controller: RTL and testbench

- Multi-cycle sequencer for the 8-bit CPU datapath: instruction memory/PC, register file and ALU.
- Splits each 24-bit instruction into FETCH/DECODE/EXEC/WB phases and drives the datapath strobes.
- Adds run/single-step control, halt and illegal-opcode detection, and a retired-instruction counter.
- Takes the opcode (Instr[23:20]) and the ALU zero flag from the datapath.

---
 rtl/cpu_seq_controller_if.sv | 32 +++
 rtl/cpu_seq_controller.sv | 132 +++++++++++++
 tb/tb_cpu_seq_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_controller_if.sv
// Bundles the datapath-facing signals of the sequencer.
// slave = the controller itself; master = whoever drives run/step/opcode/zero.
interface cpu_seq_controller_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic [3:0]       opcode;
  logic             zero;
  logic             ir_we;
  logic             pc_we;
  logic             pc_src;
  logic             reg_write;
  logic             alu_src;
  logic [1:0]       alu_control;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  run, step, opcode, zero,
    output ir_we, pc_we, pc_src, reg_write, alu_src, alu_control,
           busy, halted, illegal, retired
  );

  modport master (
    output run, step, opcode, zero,
    input  ir_we, pc_we, pc_src, reg_write, alu_src, alu_control,
           busy, halted, illegal, retired
  );
endinterface

// File: rtl/cpu_seq_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 8-bit CPU datapath,
// with run/single-step control, halt/illegal detection and a retired counter.
module cpu_seq_controller #(
  parameter int CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  cpu_seq_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, HALT
  } state_t;

  state_t           state_q, state_d;
  logic             step_prev_q;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             step_rise;
  logic             op_halt, op_beq, op_legal;
  logic [1:0]       op_alu_ctl;
  logic             op_imm;

  logic             ir_we, pc_we, pc_src, reg_write, alu_src, busy, halted;
  logic [1:0]       alu_control;

  assign step_rise = bus.step & ~step_prev_q;

  always_comb begin
    op_halt    = (bus.opcode == 4'hF);
    op_beq     = (bus.opcode == 4'h5);
    op_legal   = (bus.opcode <= 4'h5) || op_halt;
    op_imm     = (bus.opcode == 4'h4);
    op_alu_ctl = 2'b00;
    case (bus.opcode)
      4'h1, 4'h5: op_alu_ctl = 2'b01;
      4'h2:       op_alu_ctl = 2'b10;
      4'h3:       op_alu_ctl = 2'b11;
      default:    op_alu_ctl = 2'b00;
    endcase
  end

  // Next-state, counters and strobes all decode from the current state;
  // the completing phase (BEQ EXEC or WB) makes the run/idle decision.
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    retired_d   = retired_q;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    alu_control = 2'b00;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run || step_rise) state_d = FETCH;
      end
      FETCH: begin
        busy    = 1'b1;
        ir_we   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        busy = 1'b1;
        if (!op_legal) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end else if (op_halt) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        busy        = 1'b1;
        alu_control = op_alu_ctl;
        alu_src     = op_imm;
        if (op_beq) begin
          pc_we     = 1'b1;
          pc_src    = bus.zero;
          retired_d = retired_q + CNT_W'(1);
          state_d   = bus.run ? FETCH : IDLE;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        busy        = 1'b1;
        alu_control = op_alu_ctl;
        alu_src     = op_imm;
        reg_write   = 1'b1;
        pc_we       = 1'b1;
        retired_d   = retired_q + CNT_W'(1);
        state_d     = bus.run ? FETCH : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      step_prev_q <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_prev_q <= bus.step;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.pc_src      = pc_src;
  assign bus.reg_write   = reg_write;
  assign bus.alu_src     = alu_src;
  assign bus.alu_control = alu_control;
  assign bus.busy        = busy;
  assign bus.halted      = halted;
  assign bus.illegal     = illegal_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_cpu_seq_controller.sv
// Directed bench for cpu_seq_controller: a CNT_W=16 instance for the main
// sequencing cases and a CNT_W=4 instance that free-runs ADDs to show wrap.
module tb_cpu_seq_controller;

  logic clk;
  logic reset;
  logic wrap_reset;

  int vector_count;
  int miss_count;
  int first_seen;

  cpu_seq_controller_if #(.CNT_W(16)) bus ();
  cpu_seq_controller_if #(.CNT_W(4))  wbus ();

  cpu_seq_controller #(.CNT_W(16)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cpu_seq_controller #(.CNT_W(4)) dut_wrap (
    .CLK   (clk),
    .reset (wrap_reset),
    .bus   (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bundle: {ir_we, pc_we, pc_src, reg_write, alu_src, alu_control, busy, halted}
  localparam logic [8:0] S_IDLE   = 9'b0_0_0_0_0_00_0_0;
  localparam logic [8:0] S_FETCH  = 9'b1_0_0_0_0_00_1_0;
  localparam logic [8:0] S_DEC    = 9'b0_0_0_0_0_00_1_0;
  localparam logic [8:0] S_EX_ADD = 9'b0_0_0_0_0_00_1_0;
  localparam logic [8:0] S_WB_ADD = 9'b0_1_0_1_0_00_1_0;
  localparam logic [8:0] S_BEQ_T  = 9'b0_1_1_0_0_01_1_0;
  localparam logic [8:0] S_BEQ_N  = 9'b0_1_0_0_0_01_1_0;
  localparam logic [8:0] S_EX_IMM = 9'b0_0_0_0_1_00_1_0;
  localparam logic [8:0] S_WB_IMM = 9'b0_1_0_1_1_00_1_0;
  localparam logic [8:0] S_HALT   = 9'b0_0_0_0_0_00_0_1;

  function automatic logic [8:0] strobes();
    return {bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_write, bus.alu_src,
            bus.alu_control, bus.busy, bus.halted};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic step,
                               input logic [3:0] opcode, input logic zero);
    bus.run    = run;
    bus.step   = step;
    bus.opcode = opcode;
    bus.zero   = zero;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    vector_count = 0;
    miss_count   = 0;
    first_seen   = 0;
    wrap_reset   = 1'b0;
    wbus.run     = 1'b1;
    wbus.step    = 1'b0;
    wbus.opcode  = 4'h0;
    wbus.zero    = 1'b0;

    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    repeat (3) tick();
    checkOutput("reset_strobes", 32'(strobes()), 32'(S_IDLE));
    checkOutput("reset_retired", 32'(bus.retired), 32'd0);
    checkOutput("reset_illegal", 32'(bus.illegal), 32'd0);

    // Free-running ADD then two BEQs
    reset = 1'b1;
    tick(); checkOutput("add_fetch", 32'(strobes()), 32'(S_FETCH));
    tick(); checkOutput("add_decode", 32'(strobes()), 32'(S_DEC));
    tick(); checkOutput("add_exec", 32'(strobes()), 32'(S_EX_ADD));
    tick(); checkOutput("add_wb", 32'(strobes()), 32'(S_WB_ADD));
    checkOutput("add_wb_retired", 32'(bus.retired), 32'd0);
    tick(); checkOutput("add_refetch", 32'(strobes()), 32'(S_FETCH));
    checkOutput("add_retired", 32'(bus.retired), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h5, 1'b1);
    tick(); checkOutput("beq_decode", 32'(strobes()), 32'(S_DEC));
    tick(); checkOutput("beq_taken", 32'(strobes()), 32'(S_BEQ_T));
    tick(); checkOutput("beq_refetch", 32'(strobes()), 32'(S_FETCH));
    checkOutput("beq_retired", 32'(bus.retired), 32'd2);
    applyStimulus(1'b1, 1'b0, 4'h5, 1'b0);
    tick();
    tick(); checkOutput("beq_not_taken", 32'(strobes()), 32'(S_BEQ_N));
    applyStimulus(1'b0, 1'b0, 4'h5, 1'b0);
    tick(); checkOutput("run_drop_idle", 32'(strobes()), 32'(S_IDLE));
    checkOutput("run_drop_retired", 32'(bus.retired), 32'd3);

    // Single-step ADDI; held step and mid-instruction edges are ignored
    applyStimulus(1'b0, 1'b1, 4'h4, 1'b0);
    tick(); checkOutput("step_fetch", 32'(strobes()), 32'(S_FETCH));
    tick();
    tick(); checkOutput("addi_exec", 32'(strobes()), 32'(S_EX_IMM));
    tick(); checkOutput("addi_wb", 32'(strobes()), 32'(S_WB_IMM));
    tick(); checkOutput("step_done_idle", 32'(strobes()), 32'(S_IDLE));
    checkOutput("step_retired", 32'(bus.retired), 32'd4);
    repeat (3) tick();
    checkOutput("step_held_idle", 32'(strobes()), 32'(S_IDLE));
    applyStimulus(1'b0, 1'b0, 4'h4, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 4'h4, 1'b0);
    tick(); checkOutput("step2_fetch", 32'(strobes()), 32'(S_FETCH));
    applyStimulus(1'b0, 1'b0, 4'h4, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 4'h4, 1'b0);
    tick();
    tick();
    tick(); checkOutput("step2_idle", 32'(strobes()), 32'(S_IDLE));
    checkOutput("step2_retired", 32'(bus.retired), 32'd5);
    repeat (2) tick();
    checkOutput("step_mid_discard", 32'(strobes()), 32'(S_IDLE));

    // HALT opcode
    applyStimulus(1'b0, 1'b0, 4'hF, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'hF, 1'b0);
    tick();
    tick(); checkOutput("halt_state", 32'(strobes()), 32'(S_HALT));
    checkOutput("halt_retired", 32'(bus.retired), 32'd5);
    checkOutput("halt_not_illegal", 32'(bus.illegal), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b0);
    repeat (3) tick();
    checkOutput("halt_sticky", 32'(strobes()), 32'(S_HALT));
    checkOutput("halt_sticky_retired", 32'(bus.retired), 32'd5);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'hA, 1'b0);
    #1;
    checkOutput("halt_reset_strobes", 32'(strobes()), 32'(S_IDLE));
    checkOutput("halt_reset_retired", 32'(bus.retired), 32'd0);

    // Undefined opcode
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'hA, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'hA, 1'b0);
    tick();
    tick(); checkOutput("illegal_halt", 32'(strobes()), 32'(S_HALT));
    checkOutput("illegal_flag", 32'(bus.illegal), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("illegal_cleared", 32'(bus.illegal), 32'd0);
    checkOutput("illegal_reset_strobes", 32'(strobes()), 32'(S_IDLE));

    // Reset during EXEC of an ADD
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    tick();
    tick();
    tick(); checkOutput("abort_exec", 32'(strobes()), 32'(S_EX_ADD));
    reset = 1'b0;
    #1;
    checkOutput("abort_strobes", 32'(strobes()), 32'(S_IDLE));
    tick(); checkOutput("abort_no_wb", 32'(bus.reg_write), 32'd0);
    checkOutput("abort_retired", 32'(bus.retired), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    reset = 1'b1;
    tick(); checkOutput("abort_restart_idle", 32'(strobes()), 32'(S_IDLE));

    // 4-bit counter wrap over 16 free-running ADDs
    wrap_reset = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (wbus.retired == 4'd15) begin
        first_seen = i;
        break;
      end
    end
    checkOutput("wrap_reach15_cycle", 32'(first_seen), 32'd61);
    repeat (3) tick();
    checkOutput("wrap_hold15", 32'(wbus.retired), 32'd15);
    tick(); checkOutput("wrap_to_zero", 32'(wbus.retired), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
